// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared definitions for the MIPS instruction-fetch stage:
//               next-PC select codes, fetch FSM states, NOP word and the
//               default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

  // Next-PC select codes driven by the control unit (2'b11 behaves as PC+4)
  localparam logic [1:0] DIR_PC4 = 2'b00;
  localparam logic [1:0] DIR_J   = 2'b01;
  localparam logic [1:0] DIR_JR  = 2'b10;

  // Fetch FSM: FETCH talks to memory, HOLD parks a word during a stall
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_e;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;

endpackage : if_pkg
`default_nettype wire

// File: rtl/calc_pc_sig.sv
`default_nettype none
// ============================================================================
// Module      : calc_pc_sig
// Description : Combinational next-PC helper. Produces the sequential PC+4
//               and the redirect target selected by the control unit.
// Ports       : pc_i        - current fetch PC
//               pc4_ifid_i  - PC+4 of the instruction sitting in IF/ID
//               instr_idx_i - 26-bit jump index of the IF/ID instruction
//               dir_jr_i    - register target for jr
//               sel_dir_i   - next-PC select code
//               pc_mas4_o   - pc_i + 4 (wraps modulo 2^ANCHO)
//               target_o    - redirect target (pc_i when no jump selected)
// Revision    : 1.0 - initial release
// ============================================================================
module calc_pc_sig
  import if_pkg::*;
#(
  parameter int ANCHO = 32
) (
  input  logic [ANCHO-1:0] pc_i,
  input  logic [ANCHO-1:0] pc4_ifid_i,
  input  logic [25:0]      instr_idx_i,
  input  logic [ANCHO-1:0] dir_jr_i,
  input  logic [1:0]       sel_dir_i,
  output logic [ANCHO-1:0] pc_mas4_o,
  output logic [ANCHO-1:0] target_o
);

  // j only keeps the top nibble of the delay-slot PC
  logic unused_pc4_lo;
  assign unused_pc4_lo = ^pc4_ifid_i[ANCHO-5:0];

  assign pc_mas4_o = pc_i + ANCHO'(4);

  always_comb begin
    target_o = pc_i;
    case (sel_dir_i)
      DIR_J:   target_o = {pc4_ifid_i[ANCHO-1:ANCHO-4], instr_idx_i, 2'b00};
      DIR_JR:  target_o = dir_jr_i;
      default: target_o = pc_i;
    endcase
  end

endmodule : calc_pc_sig
`default_nettype wire

// File: rtl/etapa_if.sv
`default_nettype none
// ============================================================================
// Module      : etapa_if
// Description : MIPS instruction-fetch stage. Holds the PC, fetches from
//               instruction memory with a ready handshake, resolves j/jr
//               redirects and owns the IF/ID pipe register (flush + stall).
// Ports       : clk, rst_n         - clock, async active-low reset
//               SEL_DIR            - next-PC select (00 PC+4, 01 j, 10 jr)
//               resetIF            - flush IF/ID (redirect request)
//               MEM_RD_I           - active-low fetch enable from control
//               stall              - hazard hold of PC and IF/ID
//               dir_jr             - jr target
//               mem_dir, mem_rd_n  - instruction memory address / request
//               mem_dato, mem_listo- instruction word / ready
//               instr_IFID, pc4_IFID, valido_IFID - IF/ID register
// Revision    : 1.0 - initial release
// ============================================================================
module etapa_if
  import if_pkg::*;
#(
  parameter int               ANCHO    = 32,
  parameter logic [ANCHO-1:0] PC_RESET = PC_RESET_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       SEL_DIR,
  input  logic             resetIF,
  input  logic             MEM_RD_I,
  input  logic             stall,
  input  logic [ANCHO-1:0] dir_jr,
  output logic [ANCHO-1:0] mem_dir,
  output logic             mem_rd_n,
  input  logic [ANCHO-1:0] mem_dato,
  input  logic             mem_listo,
  output logic [ANCHO-1:0] instr_IFID,
  output logic [ANCHO-1:0] pc4_IFID,
  output logic             valido_IFID
);

  if_state_e        state_q;
  logic [ANCHO-1:0] pc_q;
  logic             req_q;       // request issued, ready not yet seen
  logic             pend_q;      // redirect accepted while request in flight
  logic [ANCHO-1:0] tgt_q;
  logic [ANCHO-1:0] buf_instr_q;
  logic [ANCHO-1:0] buf_pc4_q;
  logic [ANCHO-1:0] instr_q;
  logic [ANCHO-1:0] pc4_q;
  logic             valido_q;

  logic [ANCHO-1:0] pc_mas4;
  logic [ANCHO-1:0] target;
  logic             req_active;
  logic             data_ok;
  logic             jmp;
  logic             fl_only;
  logic             deliver;

  calc_pc_sig #(
    .ANCHO (ANCHO)
  ) u_calc_pc_sig (
    .pc_i        (pc_q),
    .pc4_ifid_i  (pc4_q),
    .instr_idx_i (instr_q[25:0]),
    .dir_jr_i    (dir_jr),
    .sel_dir_i   (SEL_DIR),
    .pc_mas4_o   (pc_mas4),
    .target_o    (target)
  );

  // rst_n gates the request so an in-flight fetch is dropped the moment
  // reset asserts, and the first fetch goes out right after release.
  assign mem_rd_n   = !rst_n || (state_q == HOLD) || (MEM_RD_I && !req_q);
  assign mem_dir    = pc_q;
  assign req_active = !mem_rd_n;
  assign data_ok    = req_active && mem_listo;

  // Only a real instruction in IF/ID may steer the PC
  assign jmp     = valido_q && !stall && resetIF &&
                   ((SEL_DIR == DIR_J) || (SEL_DIR == DIR_JR));
  // Flush without a PC change: IF/ID gets a bubble, the fetch stream is
  // kept intact (an arriving word is parked in the skid buffer).
  assign fl_only = resetIF && !stall && !jmp;
  assign deliver = data_ok && !pend_q && !jmp && !fl_only && !stall;

  assign instr_IFID  = instr_q;
  assign pc4_IFID    = pc4_q;
  assign valido_IFID = valido_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= PC_RESET;
      req_q       <= 1'b0;
      pend_q      <= 1'b0;
      tgt_q       <= '0;
      buf_instr_q <= NOP;
      buf_pc4_q   <= '0;
      instr_q     <= NOP;
      pc4_q       <= '0;
      valido_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          req_q <= req_active && !mem_listo;

          if (data_ok) begin
            if (pend_q || jmp) begin
              // wrong-path word: dropped, fetch restarts at the target
              pc_q   <= pend_q ? tgt_q : target;
              pend_q <= 1'b0;
            end else if (stall || fl_only) begin
              buf_instr_q <= mem_dato;
              buf_pc4_q   <= pc_mas4;
              pc_q        <= pc_mas4;
              state_q     <= HOLD;
            end else begin
              pc_q <= pc_mas4;
            end
          end else if (jmp) begin
            if (req_active) begin
              // cannot abandon the request: remember where to go next
              tgt_q  <= target;
              pend_q <= 1'b1;
            end else begin
              pc_q <= target;
            end
          end

          if (!stall) begin
            if (deliver) begin
              instr_q  <= mem_dato;
              pc4_q    <= pc_mas4;
              valido_q <= 1'b1;
            end else begin
              instr_q  <= NOP;
              pc4_q    <= '0;
              valido_q <= 1'b0;
            end
          end
        end

        HOLD: begin
          if (!stall) begin
            if (jmp) begin
              pc_q     <= target;
              state_q  <= FETCH;
              instr_q  <= NOP;
              pc4_q    <= '0;
              valido_q <= 1'b0;
            end else if (fl_only) begin
              instr_q  <= NOP;
              pc4_q    <= '0;
              valido_q <= 1'b0;
            end else begin
              instr_q  <= buf_instr_q;
              pc4_q    <= buf_pc4_q;
              valido_q <= 1'b1;
              state_q  <= FETCH;
            end
          end
        end

        default: state_q <= FETCH;
      endcase
    end
  end

endmodule : etapa_if
`default_nettype wire

// File: tb/tb_etapa_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_etapa_if
// Description : Self-checking bench for etapa_if: directed scenarios for
//               reset, sequential fetch, j/jr redirects with wait states,
//               stall, reset mid-request and ignored controls, followed by
//               a randomized run checked against an in-order program model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_etapa_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  SEL_DIR;
  logic        resetIF;
  logic        MEM_RD_I;
  logic        stall;
  logic [31:0] dir_jr;
  logic [31:0] mem_dir;
  logic        mem_rd_n;
  logic [31:0] mem_dato;
  logic        mem_listo;
  logic [31:0] instr_IFID;
  logic [31:0] pc4_IFID;
  logic        valido_IFID;

  logic [31:0] imem [0:255];
  int          mem_wait;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  // Instruction memory: word chosen by address, ready after mem_wait cycles
  assign mem_dato  = imem[mem_dir[9:2]];
  assign mem_listo = !mem_rd_n && (mem_wait == 0);

  etapa_if dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SEL_DIR     (SEL_DIR),
    .resetIF     (resetIF),
    .MEM_RD_I    (MEM_RD_I),
    .stall       (stall),
    .dir_jr      (dir_jr),
    .mem_dir     (mem_dir),
    .mem_rd_n    (mem_rd_n),
    .mem_dato    (mem_dato),
    .mem_listo   (mem_listo),
    .instr_IFID  (instr_IFID),
    .pc4_IFID    (pc4_IFID),
    .valido_IFID (valido_IFID)
  );

  task automatic chk_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] pk(input logic v, input logic [31:0] i, input logic [31:0] p);
    return {v, i, p};
  endfunction

  function automatic logic [64:0] ifid();
    return {valido_IFID, instr_IFID, pc4_IFID};
  endfunction

  function automatic logic [64:0] memq();
    return 65'({mem_rd_n, mem_dir});
  endfunction

  task automatic fill_seq();
    for (int k = 0; k < 256; k++) imem[k] = 32'hA0 + 32'(k);
  endtask

  // Hold reset two cycles, check reset state, release just after a negedge
  task automatic do_reset();
    rst_n    = 1'b0;
    SEL_DIR  = 2'b00;
    resetIF  = 1'b0;
    MEM_RD_I = 1'b0;
    stall    = 1'b0;
    dir_jr   = 32'h0;
    mem_wait = 0;
    repeat (2) @(negedge clk);
    chk_eq("rst_ifid", ifid(), 65'h0);
    chk_eq("rst_mem", memq(), 65'({1'b1, 32'h0}));
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        p_stall, p_rif, p_req, p_hs;
    logic [1:0]  p_sel;
    logic [31:0] p_jr, p_dir;
    logic        m_v;
    logic [31:0] m_i, m_p, next_pc;
    int          n_valid;

    fill_seq();

    // 1: sequential fetch, zero-wait memory
    do_reset();
    #1 chk_eq("t1_first_req", memq(), 65'h0);
    @(negedge clk) chk_eq("t1_w0", ifid(), pk(1'b1, 32'hA0, 32'h4));
    @(negedge clk) chk_eq("t1_w1", ifid(), pk(1'b1, 32'hA1, 32'h8));
    @(negedge clk) chk_eq("t1_w2", ifid(), pk(1'b1, 32'hA2, 32'hC));

    // 2: j 0x100 from address 0x8
    imem[2] = 32'h0800_0040;
    do_reset();
    repeat (3) @(negedge clk);
    chk_eq("t2_jinst", ifid(), pk(1'b1, 32'h0800_0040, 32'hC));
    resetIF = 1'b1; SEL_DIR = 2'b01;
    @(negedge clk);
    chk_eq("t2_flush", ifid(), 65'h0);
    chk_eq("t2_target", memq(), 65'({1'b0, 32'h100}));
    resetIF = 1'b0; SEL_DIR = 2'b00;
    @(negedge clk) chk_eq("t2_tgt_word", ifid(), pk(1'b1, 32'hE0, 32'h104));
    imem[2] = 32'hA2;

    // 3: jr 0x40 while the in-flight fetch at 0x4 takes 3 wait states
    do_reset();
    @(negedge clk) chk_eq("t3_w0", ifid(), pk(1'b1, 32'hA0, 32'h4));
    resetIF = 1'b1; SEL_DIR = 2'b10; dir_jr = 32'h40; mem_wait = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      resetIF = 1'b0; SEL_DIR = 2'b00;
      chk_eq("t3_wait", {valido_IFID, memq()}, 65'({1'b0, 1'b0, 32'h4}));
    end
    mem_wait = 0;
    @(negedge clk);
    chk_eq("t3_redir", {valido_IFID, memq()}, 65'({1'b0, 1'b0, 32'h40}));
    @(negedge clk) chk_eq("t3_tgt_word", ifid(), pk(1'b1, 32'hB0, 32'h44));

    // 4: 3-cycle stall while the word at 0x10 returns
    do_reset();
    repeat (4) @(negedge clk);
    chk_eq("t4_pre", ifid(), pk(1'b1, 32'hA3, 32'h10));
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_eq("t4_frozen", ifid(), pk(1'b1, 32'hA3, 32'h10));
      chk_eq("t4_norq", 65'(mem_rd_n), 65'h1);
    end
    stall = 1'b0;
    @(negedge clk);
    chk_eq("t4_release", ifid(), pk(1'b1, 32'hA4, 32'h14));
    chk_eq("t4_next_req", memq(), 65'({1'b0, 32'h14}));

    // 5: reset asserted during an outstanding request at 0x24
    do_reset();
    repeat (9) @(negedge clk);
    chk_eq("t5_at24", memq(), 65'({1'b0, 32'h24}));
    mem_wait = 1;
    #2 rst_n = 1'b0;
    #1 chk_eq("t5_drop", {valido_IFID, memq()}, 65'({1'b0, 1'b1, 32'h0}));
    @(negedge clk);
    mem_wait = 0;
    rst_n = 1'b1;
    #1 chk_eq("t5_restart", memq(), 65'h0);
    @(negedge clk) chk_eq("t5_w0", ifid(), pk(1'b1, 32'hA0, 32'h4));

    // 6: SEL_DIR=11 without resetIF, then resetIF blocked by stall
    do_reset();
    @(negedge clk) chk_eq("t6_w0", ifid(), pk(1'b1, 32'hA0, 32'h4));
    SEL_DIR = 2'b11;
    @(negedge clk) chk_eq("t6_sel11", ifid(), pk(1'b1, 32'hA1, 32'h8));
    resetIF = 1'b1; SEL_DIR = 2'b01; stall = 1'b1;
    @(negedge clk) chk_eq("t6_stall_rif", ifid(), pk(1'b1, 32'hA1, 32'h8));
    resetIF = 1'b0; SEL_DIR = 2'b00; stall = 1'b0;
    @(negedge clk) chk_eq("t6_w2", ifid(), pk(1'b1, 32'hA2, 32'hC));
    @(negedge clk) chk_eq("t6_w3", ifid(), pk(1'b1, 32'hA3, 32'h10));

    // Random run: IF/ID must show the program in order, following taken jumps
    for (int k = 0; k < 256; k++) imem[k] = $urandom;
    do_reset();
    m_v = 1'b0; m_i = 32'h0; m_p = 32'h0; next_pc = 32'h0;
    p_hs = 1'b0; p_req = 1'b0; n_valid = 0;
    for (int c = 0; c < 1500; c++) begin
      if (p_hs) mem_wait = ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
      else if (p_req && mem_wait > 0) mem_wait--;
      stall    = ($urandom % 5 == 0);
      resetIF  = ($urandom % 6 == 0);
      SEL_DIR  = resetIF ? (($urandom % 2 == 0) ? 2'b01 : 2'b10) : 2'($urandom % 4);
      MEM_RD_I = ($urandom % 8 == 0);
      dir_jr   = $urandom & 32'hFFFF_FFFC;
      #4;
      p_stall = stall; p_rif = resetIF; p_sel = SEL_DIR; p_jr = dir_jr;
      p_req = !mem_rd_n; p_hs = !mem_rd_n && mem_listo; p_dir = mem_dir;
      @(negedge clk);
      if (p_req && !p_hs) chk_eq("rnd_req_stable", memq(), 65'({1'b0, p_dir}));
      if (p_stall) begin
        chk_eq("rnd_stall", ifid(), pk(m_v, m_i, m_p));
      end else if (p_rif) begin
        if (m_v && p_sel == 2'b01)
          next_pc = (m_p & 32'hF000_0000) | ((m_i & 32'h03FF_FFFF) << 2);
        else if (m_v && p_sel == 2'b10)
          next_pc = p_jr;
        chk_eq("rnd_flush", ifid(), 65'h0);
        m_v = 1'b0; m_i = 32'h0; m_p = 32'h0;
      end else if (valido_IFID) begin
        chk_eq("rnd_seq", ifid(), pk(1'b1, imem[next_pc[9:2]], next_pc + 32'h4));
        m_v = 1'b1; m_i = imem[next_pc[9:2]]; m_p = next_pc + 32'h4;
        next_pc = next_pc + 32'h4;
        n_valid++;
      end else begin
        chk_eq("rnd_bubble", ifid(), 65'h0);
        m_v = 1'b0; m_i = 32'h0; m_p = 32'h0;
      end
    end
    chk_eq("rnd_progress", 65'(n_valid > 200), 65'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_etapa_if
`default_nettype wire
